spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_master.sv | 163 ++++++++++++++++
 tb/tb_spi_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, datapath widths and mode-0 idle levels.
package spi_pkg;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int DIV_W  = 8;
  localparam int CNT_W  = LEN_W + 1;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    RECOVER,
    RESP
  } state_t;
endpackage

// File: rtl/spi_master_if.sv
// Request/response handshake plus SPI pins of the master, with master and host-side views.
interface spi_master_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] tx_data;
  logic [LEN_W-1:0]  len;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] rx_data;
  logic              sck;
  logic              ss;
  logic              mosi;
  logic              miso;

  modport master (
    input  req_valid, tx_data, len, resp_ready, miso,
    output req_ready, resp_valid, rx_data, sck, ss, mosi
  );

  modport slave (
    output req_valid, tx_data, len, resp_ready, miso,
    input  req_ready, resp_valid, rx_data, sck, ss, mosi
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: load restarts a DIV-cycle interval, tick marks its last cycle.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Counts down and parks at zero; it never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one transfer of 1..16 bits per request, then SS-high recovery pulses.
module spi_master
  import spi_pkg::*;
#(
  parameter int DIV            = 2,
  parameter int RECOVER_PULSES = 1
) (
  input  logic         clock,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam logic [LEN_W-1:0] RP_LAST = LEN_W'(RECOVER_PULSES - 1);

  state_t            state, state_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [LEN_W-1:0]  pulse_cnt, pulse_cnt_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              req_ready;
  logic              phase_load;
  logic              load;
  logic              tick;

  assign req_ready = (state == IDLE);

  spi_clk_div #(.DIV(DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .tick  (tick)
  );

  // RECOVER toggles sck without leaving the state, so it restarts the divider itself.
  assign load = (state_d != state) || phase_load;

  always_comb begin
    state_d      = state;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    resp_valid_d = resp_valid_q;
    rx_data_d    = rx_data_q;
    bit_cnt_d    = bit_cnt;
    pulse_cnt_d  = pulse_cnt;
    tx_shift_d   = tx_shift;
    rx_shift_d   = rx_shift;
    len_d        = len_q;
    phase_load   = 1'b0;
    unique case (state)
      IDLE: begin
        sck_d  = SCK_IDLE;
        ss_d   = SS_IDLE;
        mosi_d = MOSI_IDLE;
        if (bus.req_valid && req_ready) begin
          tx_shift_d  = bus.tx_data;
          len_d       = bus.len;
          rx_shift_d  = '0;
          bit_cnt_d   = '0;
          pulse_cnt_d = '0;
          ss_d        = 1'b0;
          mosi_d      = bus.tx_data[DATA_W-1];
          state_d     = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift[DATA_W-2:0], bus.miso};
          bit_cnt_d  = bit_cnt + CNT_W'(1);
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt == ({1'b0, len_q} + CNT_W'(1))) begin
            state_d = HOLD;
          end else begin
            tx_shift_d = {tx_shift[DATA_W-2:0], 1'b0};
            mosi_d     = tx_shift[DATA_W-2];
            state_d    = LOW;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ss_d    = SS_IDLE;
          mosi_d  = MOSI_IDLE;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d      = 1'b1;
            phase_load = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (pulse_cnt == RP_LAST) begin
              resp_valid_d = 1'b1;
              rx_data_d    = rx_shift;
              state_d      = RESP;
            end else begin
              pulse_cnt_d = pulse_cnt + LEN_W'(1);
              phase_load  = 1'b1;
            end
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sck_q        <= SCK_IDLE;
      ss_q         <= SS_IDLE;
      mosi_q       <= MOSI_IDLE;
      resp_valid_q <= 1'b0;
      rx_data_q    <= '0;
      bit_cnt      <= '0;
      pulse_cnt    <= '0;
    end else begin
      state        <= state_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
      rx_data_q    <= rx_data_d;
      bit_cnt      <= bit_cnt_d;
      pulse_cnt    <= pulse_cnt_d;
    end
  end

  // Shift registers and latched length are reloaded at every transfer start.
  always_ff @(posedge clock) begin
    tx_shift <= tx_shift_d;
    rx_shift <= rx_shift_d;
    len_q    <= len_d;
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.sck        = sck_q;
  assign bus.ss         = ss_q;
  assign bus.mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (DIV=2/RP=1 and DIV=1/RP=2) sharing one host.
module tb_spi_master;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        sel        = 1'b0;
  logic [1:0]  miso_mode  = 2'd0;
  logic        req_valid  = 1'b0;
  logic        resp_ready = 1'b0;
  logic [15:0] tx_data    = 16'h0;
  logic [3:0]  len        = 4'h0;

  spi_master_if bus_a ();
  spi_master_if bus_b ();

  assign bus_a.req_valid  = req_valid & ~sel;
  assign bus_b.req_valid  = req_valid & sel;
  assign bus_a.resp_ready = resp_ready & ~sel;
  assign bus_b.resp_ready = resp_ready & sel;
  assign bus_a.tx_data    = tx_data;
  assign bus_b.tx_data    = tx_data;
  assign bus_a.len        = len;
  assign bus_b.len        = len;
  assign bus_a.miso       = (miso_mode == 2'd0) ? bus_a.mosi : (miso_mode == 2'd1);
  assign bus_b.miso       = (miso_mode == 2'd0) ? bus_b.mosi : (miso_mode == 2'd1);

  spi_master #(.DIV(2), .RECOVER_PULSES(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  spi_master #(.DIV(1), .RECOVER_PULSES(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  logic        o_sck, o_ss, o_mosi, o_req_ready, o_resp_valid;
  logic [15:0] o_rx;
  assign o_sck        = sel ? bus_b.sck        : bus_a.sck;
  assign o_ss         = sel ? bus_b.ss         : bus_a.ss;
  assign o_mosi       = sel ? bus_b.mosi       : bus_a.mosi;
  assign o_req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign o_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign o_rx         = sel ? bus_b.rx_data    : bus_a.rx_data;

  // Pin monitor, sampled on the falling clock edge.
  int   rise_lo = 0, rise_hi = 0, ss_low_cyc = 0, ss_falls = 0, mosi_viol = 0;
  logic p_sck = 1'b0, p_ss = 1'b1, p_mosi = 1'b1;
  always @(negedge clock) begin
    p_sck  <= o_sck;
    p_ss   <= o_ss;
    p_mosi <= o_mosi;
    if (o_sck && !p_sck) begin
      if (o_ss) rise_hi <= rise_hi + 1;
      else      rise_lo <= rise_lo + 1;
    end
    if (!o_ss) ss_low_cyc <= ss_low_cyc + 1;
    if (!o_ss && p_ss) ss_falls <= ss_falls + 1;
    if ((o_mosi != p_mosi) && !(p_sck && !o_sck) && (o_ss == p_ss)) mosi_viol <= mosi_viol + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] r_rx;
  int          r_lo, r_hi, r_sl, r_mv;
  logic        r_to, r_stable, r_done;

  task automatic run_xfer(input logic s, input logic [15:0] tx, input logic [3:0] l,
                          input logic [1:0] mm, input int hold);
    int b_lo, b_hi, b_sl, b_mv, n;
    sel = s;
    miso_mode = mm;
    @(negedge clock);
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    b_lo = rise_lo; b_hi = rise_hi; b_sl = ss_low_cyc; b_mv = mosi_viol;
    tx_data = tx;
    len = l;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!o_resp_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    r_to = !o_resp_valid;
    r_rx = o_rx;
    r_lo = rise_lo - b_lo;
    r_hi = rise_hi - b_hi;
    r_sl = ss_low_cyc - b_sl;
    r_mv = mosi_viol - b_mv;
    r_stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if (!o_resp_valid || o_rx != r_rx || o_req_ready || o_sck || !o_ss) r_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    r_done = !o_resp_valid && o_req_ready;
  endtask

  typedef struct {
    logic        s;
    logic [15:0] tx;
    logic [3:0]  l;
    logic [1:0]  mm;
    int          hold;
    logic [15:0] rx;
    int          lo;
    int          hi;
    int          sl;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int b_lo, b_hi, b_sl, b_fall, n;

    // Asynchronous reset, checked before the first rising clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst ss", bus_a.ss, 1);
    check("rst sck", bus_a.sck, 0);
    check("rst mosi", bus_a.mosi, 1);
    check("rst resp_valid", bus_a.resp_valid, 0);
    check("rst rx_data", bus_a.rx_data, 16'h0);
    check("rst req_ready", bus_a.req_ready, 1);
    check("rst b ss", bus_b.ss, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // sel, tx, len, miso(0 loop,1 high,2 low), hold, rx, rises ss low, rises ss high, ss low cycles
    vecs[0] = '{1'b0, 16'hA5C3, 4'd15, 2'd0, 20, 16'hA5C3, 16, 1, 66};
    vecs[1] = '{1'b1, 16'h5A00, 4'd7,  2'd0, 0,  16'h005A, 8,  2, 17};
    vecs[2] = '{1'b0, 16'h0000, 4'd0,  2'd1, 0,  16'h0001, 1,  1, 6};
    vecs[3] = '{1'b1, 16'h8000, 4'd0,  2'd1, 0,  16'h0001, 1,  2, 3};
    vecs[4] = '{1'b0, 16'h3C00, 4'd3,  2'd0, 0,  16'h0003, 4,  1, 18};
    vecs[5] = '{1'b0, 16'hFFFF, 4'd15, 2'd2, 0,  16'h0000, 16, 1, 66};
    vecs[6] = '{1'b1, 16'h1234, 4'd15, 2'd0, 0,  16'h1234, 16, 2, 33};
    vecs[7] = '{1'b0, 16'hC000, 4'd1,  2'd0, 0,  16'h0003, 2,  1, 10};
    vecs[8] = '{1'b1, 16'hFFFF, 4'd11, 2'd1, 0,  16'h0FFF, 12, 2, 25};

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].s, vecs[i].tx, vecs[i].l, vecs[i].mm, vecs[i].hold);
      check($sformatf("v%0d timeout", i), r_to, 0);
      check($sformatf("v%0d rx_data", i), r_rx, vecs[i].rx);
      check($sformatf("v%0d rises ss low", i), r_lo, vecs[i].lo);
      check($sformatf("v%0d rises ss high", i), r_hi, vecs[i].hi);
      check($sformatf("v%0d ss low cycles", i), r_sl, vecs[i].sl);
      check($sformatf("v%0d mosi edge rule", i), r_mv, 0);
      check($sformatf("v%0d handshake done", i), r_done, 1);
      if (vecs[i].hold > 0) check($sformatf("v%0d resp stable", i), r_stable, 1);
    end

    // req_valid held and tx_data/len changed mid-transfer; resp_ready high throughout.
    sel = 1'b0;
    miso_mode = 2'd0;
    resp_ready = 1'b1;
    @(negedge clock);
    b_fall = ss_falls;
    b_lo = rise_lo;
    tx_data = 16'hC3A5;
    len = 4'd15;
    req_valid = 1'b1;
    n = 0;
    while ((rise_lo - b_lo) < 4 && n < 200) begin
      @(negedge clock);
      n++;
    end
    tx_data = 16'h0F0F;
    len = 4'd3;
    n = 0;
    while (!o_resp_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("held req resp seen", o_resp_valid, 1);
    check("held req rx_data", o_rx, 16'hC3A5);
    req_valid = 1'b0;
    @(negedge clock);
    check("held req resp dropped", o_resp_valid, 0);
    check("held req idle", o_req_ready, 1);
    resp_ready = 1'b0;
    repeat (10) @(negedge clock);
    check("held req one transfer", ss_falls - b_fall, 1);
    check("held req rises", rise_lo - b_lo, 16);

    // Reset during the 5th bit's HIGH phase.
    sel = 1'b0;
    @(negedge clock);
    b_lo = rise_lo;
    tx_data = 16'hFFFF;
    len = 4'd15;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while ((rise_lo - b_lo) < 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("abort reached bit5", rise_lo - b_lo, 5);
    check("abort sck high", o_sck, 1);
    #1 reset = 1'b1;
    #1;
    check("abort ss", o_ss, 1);
    check("abort sck", o_sck, 0);
    check("abort resp_valid", o_resp_valid, 0);
    check("abort mosi", o_mosi, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    b_lo = rise_lo;
    b_hi = rise_hi;
    b_sl = ss_low_cyc;
    repeat (10) @(negedge clock);
    check("abort no sck rises", (rise_lo - b_lo) + (rise_hi - b_hi), 0);
    check("abort ss stays high", ss_low_cyc - b_sl, 0);
    run_xfer(1'b0, 16'h1234, 4'd15, 2'd0, 0);
    check("post reset timeout", r_to, 0);
    check("post reset rx_data", r_rx, 16'h1234);
    check("post reset rises", r_lo, 16);
    check("post reset ss low", r_sl, 66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
